// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity support is selected by UART_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator, one pulse every TICK_DIV clocks.
// Shared between the UART receive and transmit paths.
module uart_baud_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for an even parity bit and a parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int TICK_DIV     = SYS_CLK_FREQ / (BAUD_RATE * 16)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [3:0] MID_CNT = 4'(HALF_BIT - 1);
    localparam logic [3:0] END_CNT = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic       tick;
    logic       rx_s;
    logic [1:0] sync_q;
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       armed_q, armed_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       complete;
    logic       hs;
`ifdef UART_RX_PARITY_EN
    logic       pbad_q, pbad_d;
    logic       perr_q, perr_d;
`endif

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    assign rx_s = sync_q[1];
    assign hs   = valid_q & rx_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        armed_d  = armed_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        complete = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d   = pbad_q;
        perr_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_s) armed_d = 1'b1;
                if (tick && armed_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: if (tick) begin
                if (cnt_q == MID_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        // Too short to be a start bit: treat as line noise.
                        state_d = IDLE;
                        armed_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: if (tick) begin
                if (cnt_q == END_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == LAST_BIT) state_d = PARITY;
`else
                    if (bit_q == LAST_BIT) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                if (cnt_q == END_CNT) begin
                    cnt_d   = '0;
                    pbad_d  = (^shift_q) ^ rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: if (tick) begin
                if (cnt_q == END_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        // Stay disarmed so a held break cannot start a frame.
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        armed_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (pbad_q) perr_d = 1'b1;
                        else        complete = 1'b1;
`else
                        complete = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (hs) valid_d = 1'b0;
        if (complete) begin
            if (!valid_q || hs) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbad_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            pbad_q <= pbad_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int BIT_CLKS = 16;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_b;
        int         exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int vcyc = 0;
    int both_cnt = 0;

    int b_got, b_fe, b_ov, b_pe, b_vc;

    always #5 clk = ~clk;

    uart_rx #(
        .SYS_CLK_FREQ(1600000),
        .BAUD_RATE   (100000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    // Event monitor: consumer handshakes and error pulses.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (rx_valid) vcyc++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_got = got.size();
        b_fe  = fe_cnt;
        b_ov  = ov_cnt;
        b_pe  = pe_cnt;
        b_vc  = vcyc;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        step(BIT_CLKS);
    endtask

    // Start bit, data LSB first and, when enabled, the parity bit.
    task automatic send_body(input logic [7:0] d, input logic pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ pflip);
`else
        if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic pflip);
        send_body(d, pflip);
        send_bit(stop);
        rx = 1'b1;
    endtask

    function automatic int got_at(input int idx);
        if (idx < got.size()) return int'(got[idx]);
        return -1;
    endfunction

    vec_t       tbl[6];
    logic [7:0] exp_q[$];
    int         exp_fe;
    logic [7:0] rd;
    logic       rs;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        tbl[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        tbl[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        tbl[3] = '{8'h55, 1'b0, 0, 8'h00, 1};
        tbl[4] = '{8'h80, 1'b1, 1, 8'h80, 0};
        tbl[5] = '{8'h01, 1'b1, 1, 8'h01, 0};

        step(3);
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset rx_data", int'(rx_data), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset overrun", int'(overrun), 0);
        rst_n = 1'b1;
        step(2 * BIT_CLKS);

        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(tbl[i].data, tbl[i].stop, 1'b0);
            step(2 * BIT_CLKS);
            check($sformatf("tbl%0d count", i), got.size() - b_got, tbl[i].exp_n);
            if (tbl[i].exp_n > 0)
                check($sformatf("tbl%0d byte", i), got_at(b_got), int'(tbl[i].exp_b));
            check($sformatf("tbl%0d valid_cycles", i), vcyc - b_vc, tbl[i].exp_n);
            check($sformatf("tbl%0d frame_err", i), fe_cnt - b_fe, tbl[i].exp_fe);
            check($sformatf("tbl%0d overrun", i), ov_cnt - b_ov, 0);
        end

        // Overrun: hold the first byte while a second completes.
        rx_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        step(2 * BIT_CLKS);
        check("ovr rx_valid held", int'(rx_valid), 1);
        check("ovr rx_data held", int'(rx_data), 8'h3C);
        check("ovr pulses", ov_cnt - b_ov, 1);
        check("ovr no delivery", got.size() - b_got, 0);
        check("ovr frame_err", fe_cnt - b_fe, 0);
        rx_ready = 1'b1;
        step(1);
        check("ovr valid falls", int'(rx_valid), 0);
        check("ovr delivered", got_at(b_got), 8'h3C);
        check("ovr delivered once", got.size() - b_got, 1);

        // Bad stop bit followed by a long break, then a clean byte.
        snap();
        send_body(8'h55, 1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        step(40 * BIT_CLKS);
        rx = 1'b1;
        step(2 * BIT_CLKS);
        send_frame(8'h12, 1'b1, 1'b0);
        step(2 * BIT_CLKS);
        check("brk frame_err", fe_cnt - b_fe, 1);
        check("brk count", got.size() - b_got, 1);
        check("brk byte", got_at(b_got), 8'h12);
        check("brk overrun", ov_cnt - b_ov, 0);

        // Short low glitch is not a start bit.
        snap();
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(2 * BIT_CLKS);
        check("glitch count", got.size() - b_got, 0);
        check("glitch frame_err", fe_cnt - b_fe, 0);
        send_frame(8'hFF, 1'b1, 1'b0);
        step(2 * BIT_CLKS);
        check("glitch next count", got.size() - b_got, 1);
        check("glitch next byte", got_at(b_got), 8'hFF);

        // Reset in the middle of 0x7E, then 0x42.
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b1;
        step(5);
        rst_n = 1'b0;
        step(2);
        check("rst rx_valid", int'(rx_valid), 0);
        check("rst rx_data", int'(rx_data), 0);
        check("rst frame_err", int'(frame_err), 0);
        check("rst overrun", int'(overrun), 0);
        rst_n = 1'b1;
        step(2 * BIT_CLKS);
        send_frame(8'h42, 1'b1, 1'b0);
        step(2 * BIT_CLKS);
        check("rst count", got.size() - b_got, 1);
        check("rst byte", got_at(b_got), 8'h42);
        check("rst frame_err cnt", fe_cnt - b_fe, 0);

        // Random frames against a frame-level reference model.
        snap();
        exp_q.delete();
        exp_fe = 0;
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rs, 1'b0);
            step($urandom_range(1, 20));
            if (rs) exp_q.push_back(rd);
            else    exp_fe++;
        end
        step(2 * BIT_CLKS);
        check("rand count", got.size() - b_got, exp_q.size());
        foreach (exp_q[i])
            check($sformatf("rand byte%0d", i), got_at(b_got + i), int'(exp_q[i]));
        check("rand frame_err", fe_cnt - b_fe, exp_fe);
        check("rand overrun", ov_cnt - b_ov, 0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        step(2 * BIT_CLKS);
        check("par ok count", got.size() - b_got, 1);
        check("par ok byte", got_at(b_got), 8'h07);
        check("par ok perr", pe_cnt - b_pe, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        step(2 * BIT_CLKS);
        check("par bad perr", pe_cnt - b_pe, 1);
        check("par bad count", got.size() - b_got, 0);
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        step(2 * BIT_CLKS);
        check("par+stop perr", pe_cnt - b_pe, 0);
        check("par+stop ferr", fe_cnt - b_fe, 1);
        check("par+stop count", got.size() - b_got, 0);
`endif

        check("ferr and ovr together", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive endpoint for the SoC's UART line; the counterpart of the UART transmitter driven from the CPU side of riscv_top.
- Samples an asynchronous 8N1 RX line at 16x oversampling and deframes each character.
- Presents each byte on a one-entry valid/ready holding register to the HCI/host-interface logic.
- Flags framing errors and overruns.

Parameters:
- SYS_CLK_FREQ, 100000000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- TICK_DIV, SYS_CLK_FREQ/(BAUD_RATE*16): clk cycles per oversample tick; must be at least 1; integer division truncates.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line; idle high; asynchronous to clk.
- rx_data  out  8  received byte; valid only while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: byte completed while holding register full.

Behaviour:
- Reset values (async, rst_n=0):
  - State IDLE.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops =1; tick counter=0; armed=0.
- Input sync: 2-flop synchronizer on rx. All logic uses the synchronized rx_s (2-cycle latency).
- Tick generator: free-running counter 0..TICK_DIV-1. tick pulses one clk when the counter wraps to 0.
- Sample counter: 4-bit, advances only on tick.
- IDLE:
  - armed sets when rx_s=1.
  - On a tick with armed=1 and rx_s=0 → START, sample counter cleared.
- START:
  - After 8 ticks (mid start bit), if rx_s=0 → DATA with bit index 0 and counter cleared.
  - If rx_s=1, the start was a glitch → IDLE with armed=1.
- DATA:
  - Every 16 ticks, sample rx_s into shift register, LSB first.
  - After bit index 7 → STOP (or PARITY when enabled).
- STOP (after 16 ticks, i.e. mid stop bit):
  - rx_s=1 → byte complete; go to IDLE with armed=1.
  - rx_s=0 → frame_err pulses 1 cycle; byte discarded; go to IDLE with armed=0, so a break/low line cannot start a new frame until rx_s returns high.
- Holding register:
  - On byte complete with rx_valid=0: the next clk loads rx_data and sets rx_valid=1.
  - rx_valid stays 1 and rx_data stays stable until a clk where rx_valid & rx_ready; that clk clears rx_valid.
  - Complete while rx_valid=1 and no handshake in that same cycle: new byte dropped, old byte kept, overrun pulses 1 cycle.
  - Complete in the same cycle as a handshake: new byte loaded, rx_valid stays 1, no overrun.
- frame_err and overrun never assert together; a framed-bad byte never reaches rx_data.
- Reset mid-frame aborts immediately. After release, the receiver waits for rx_s=1 (armed) before accepting any start.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled 16 ticks after the last data bit.
  - Parity is even: XOR of the 8 data bits and the parity bit must be 0.
  - Adds output port parity_err, a one-cycle pulse at stop-bit sample time in place of byte completion; the byte is discarded.
  - If both parity and stop bit are bad, only frame_err pulses.
- Undefined: no PARITY state, no parity_err port; frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - The state enum (IDLE, START, DATA, PARITY, STOP).
  - OVERSAMPLE=16 and HALF_BIT=8.
  - DATA_BITS=8.
- Sub-module uart_baud_tick: parameterized tick generator (TICK_DIV), output tick. Natural to share with the future uart_tx.

Test Plan:
- Params SYS_CLK_FREQ=1600000, BAUD_RATE=100000 (TICK_DIV=1, 16 clk/bit). Send 0xA5 8N1, rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5; frame_err=overrun=0.
- Send 0x3C, hold rx_ready=0, then send 0x81 → rx_data stays 0x3C with rx_valid=1; overrun pulses once at 0x81's stop sample. Then rx_ready=1 → rx_valid falls the next clk.
- Send 0x55 with stop bit driven 0, then hold rx low 40 bit times, then high 2 bit times, then send 0x12 → one frame_err pulse, no rx_valid for 0x55, no spurious bytes during the break, rx_data=0x12 received.
- Glitch: rx low for 4 clk then high → state returns to IDLE, no rx_valid, no frame_err. A following 0xFF is received correctly.
- Assert rst_n=0 during bit 3 of 0x7E, release, send 0x42 → outputs 0 during reset; only 0x42 is delivered.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → rx_data=0x07. Same byte with parity bit 0 → parity_err pulse, no rx_valid.
